sram_bist_sched: RTL

- Sequences memory BIST across all SRAM banks of the AHB SRAM controller.
- Sits directly upstream of the per-bank mbist_8kx8 instances: drives each bank's b_te, and consumes each bank's b_done/b_fail.
- Runs one bank at a time to bound test peak current.
- Aggregates a per-bank fail map, an overall pass/fail, and a watchdog error for software/ATE.

---
 rtl/sram_bist_pkg.sv | 26 ++
 rtl/bist_wdog.sv | 40 ++++
 rtl/sram_bist_sched.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/sram_bist_pkg.sv
// Shared definitions for the SRAM BIST scheduler.
//   - bist_state_e : scheduler FSM encoding (idle, bank under test, inter-bank gap, finish)
//   - Def*         : default scheduler parameters
//   - March*       : nominal length of one 8kx8 march run, used to size the watchdog default
package sram_bist_pkg;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StRun  = 2'd1,
      StGap  = 2'd2,
      StFin  = 2'd3
   } bist_state_e;

   localparam int unsigned DefNumBanks  = 8;
   localparam int unsigned DefGapCycles = 4;
   localparam int unsigned DefToW       = 18;

   // One march over 8192 words is 26 passes plus a short idle preamble/postamble.
   localparam int unsigned MarchIdleCycles = 64;
   localparam int unsigned MarchCycles     = 26 * 8192 + MarchIdleCycles;

   // Margin above a nominal march so a healthy bank never trips the watchdog.
   localparam int unsigned WdogMargin  = 26944;
   localparam int unsigned DefToCycles = MarchCycles + WdogMargin;

endpackage

// File: rtl/bist_wdog.sv
// Clearable up-counter with a terminal-count pulse. Used for both the per-bank watchdog
// and the inter-bank gap timer.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear to zero (wins over en)
//   en         : count enable
//   limit      : terminal count
//   expired    : combinational pulse while enabled and the count equals limit
module bist_wdog #(
   parameter int unsigned W = 18
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         en,
   input  logic [W-1:0] limit,
   output logic         expired
);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = cnt_q + W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired = en & ~clr & (cnt_q == limit);

endmodule

// File: rtl/sram_bist_sched.sv
// Sequences memory BIST over all SRAM banks, one bank at a time, and collects results.
// Optional feature macro: SRAM_BIST_SCHED_WDOG_EN (per-bank watchdog; off by default).
//   b_clk, b_rst_n : BIST clock, asynchronous active-low reset (shared with the mbists)
//   bist_start     : single-cycle start request, ignored while busy
//   bist_abort     : level abort, effective in RUN/GAP
//   bank_done/fail : per-bank mbist b_done pulse / b_fail
//   bank_te        : per-bank b_te, registered, one-hot or zero
//   bist_busy      : run in progress
//   bist_done      : sticky run-complete flag
//   bist_fail      : any bank failed or run timed out / aborted
//   fail_map       : per-bank fail flags
//   timeout_err    : watchdog fired or run aborted
//   cur_bank       : index of the bank under test
module sram_bist_sched
   import sram_bist_pkg::*;
#(
   parameter int unsigned NUM_BANKS  = DefNumBanks,
   parameter int unsigned GAP_CYCLES = DefGapCycles,
   parameter int unsigned TO_W       = DefToW,
   parameter int unsigned TO_CYCLES  = DefToCycles,
   localparam int unsigned IdxW      = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
   input  logic                 b_clk,
   input  logic                 b_rst_n,
   input  logic                 bist_start,
   input  logic                 bist_abort,
   input  logic [NUM_BANKS-1:0] bank_done,
   input  logic [NUM_BANKS-1:0] bank_fail,
   output logic [NUM_BANKS-1:0] bank_te,
   output logic                 bist_busy,
   output logic                 bist_done,
   output logic                 bist_fail,
   output logic [NUM_BANKS-1:0] fail_map,
   output logic                 timeout_err,
   output logic [IdxW-1:0]      cur_bank
);

   if (GAP_CYCLES < 2 || TO_CYCLES < 2 || TO_CYCLES > (1 << TO_W)) begin : g_bad_cfg
      $error("sram_bist_sched: invalid GAP_CYCLES/TO_CYCLES/TO_W");
   end

   localparam logic [IdxW-1:0]      LastIdx  = IdxW'(NUM_BANKS - 1);
   localparam logic [NUM_BANKS-1:0] OneHot0  = NUM_BANKS'(1);
   localparam logic [TO_W-1:0]      GapLimit = TO_W'(GAP_CYCLES - 1);

   bist_state_e          state_q, state_d;
   logic [IdxW-1:0]      idx_q, idx_d;
   logic [NUM_BANKS-1:0] te_q, te_d;
   logic [NUM_BANKS-1:0] fmap_q, fmap_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic                 tout_q, tout_d;
   logic                 gap_expired;
   logic                 wdog_expired;

   // Gap timer is held clear outside GAP, so each gap starts counting from zero.
   bist_wdog #(
      .W (TO_W)
   ) u_gap (
      .clk     (b_clk),
      .rst_n   (b_rst_n),
      .clr     (state_q != StGap),
      .en      (state_q == StGap),
      .limit   (GapLimit),
      .expired (gap_expired)
   );

`ifdef SRAM_BIST_SCHED_WDOG_EN
   localparam logic [TO_W-1:0] ToLimit = TO_W'(TO_CYCLES - 1);

   bist_wdog #(
      .W (TO_W)
   ) u_wdog (
      .clk     (b_clk),
      .rst_n   (b_rst_n),
      .clr     (state_q != StRun),
      .en      (state_q == StRun),
      .limit   (ToLimit),
      .expired (wdog_expired)
   );
`else
   assign wdog_expired = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      te_d    = te_q;
      fmap_d  = fmap_q;
      busy_d  = busy_q;
      done_d  = done_q;
      tout_d  = tout_q;
      unique case (state_q)
         StIdle: begin
            // Start wins over a coincident abort; abort is seen from the next cycle.
            if (bist_start) begin
               fmap_d  = '0;
               done_d  = 1'b0;
               tout_d  = 1'b0;
               idx_d   = '0;
               te_d    = OneHot0;
               busy_d  = 1'b1;
               state_d = StRun;
            end
         end
         StRun: begin
            if (bist_abort) begin
               te_d    = '0;
               tout_d  = 1'b1;
               state_d = StFin;
            end else if (bank_done[idx_q]) begin
               // te must drop on the done edge or the mbist restarts its march.
               // b_fail is only meaningful in the done cycle.
               te_d          = '0;
               fmap_d[idx_q] = bank_fail[idx_q];
               state_d       = StGap;
            end else if (wdog_expired) begin
               te_d          = '0;
               fmap_d[idx_q] = 1'b1;
               tout_d        = 1'b1;
               state_d       = StGap;
            end
         end
         StGap: begin
            if (bist_abort) begin
               tout_d  = 1'b1;
               state_d = StFin;
            end else if (gap_expired) begin
               if (idx_q == LastIdx) begin
                  state_d = StFin;
               end else begin
                  idx_d   = idx_q + IdxW'(1);
                  te_d    = OneHot0 << idx_d;
                  state_d = StRun;
               end
            end
         end
         StFin: begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge b_clk or negedge b_rst_n) begin
      if (!b_rst_n) begin
         state_q <= StIdle;
         idx_q   <= '0;
         te_q    <= '0;
         fmap_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         tout_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         te_q    <= te_d;
         fmap_q  <= fmap_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         tout_q  <= tout_d;
      end
   end

   assign bank_te     = te_q;
   assign bist_busy   = busy_q;
   assign bist_done   = done_q;
   assign fail_map    = fmap_q;
   assign timeout_err = tout_q;
   assign bist_fail   = (|fmap_q) | tout_q;
   assign cur_bank    = idx_q;

endmodule
